// File: rtl/mode_ctrl_pkg.sv
// Shared definitions for the piano mode sequencer: mode and cursor codes,
// button lane indices, FSM state and event types, and small wrap helpers.
package mode_ctrl_pkg;

    // Default system clock; debounce and mute defaults are derived from it.
    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    // Mode codes seen by the signal selector and the players.
    localparam logic [2:0] MODE_MENU  = 3'b000;
    localparam logic [2:0] MODE_FREE  = 3'b001;
    localparam logic [2:0] MODE_AUTO  = 3'b011;
    localparam logic [2:0] MODE_LEARN = 3'b111;

    // Menu cursor codes.
    localparam logic [1:0] CUR_FREE  = 2'd0;
    localparam logic [1:0] CUR_AUTO  = 2'd1;
    localparam logic [1:0] CUR_LEARN = 2'd2;

    // Button lanes in the debounced press vector.
    localparam int BTN_CNT  = 5;
    localparam int BTN_NEXT = 0;
    localparam int BTN_OK   = 1;
    localparam int BTN_BACK = 2;
    localparam int BTN_UP   = 3;
    localparam int BTN_DOWN = 4;

    typedef enum logic [1:0] {
        ST_MENU,
        ST_FREE,
        ST_AUTO,
        ST_LEARN
    } state_t;

    // At most one event is acted on per cycle; this is the winner.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_BACK,
        EV_OK,
        EV_NEXT,
        EV_UP,
        EV_DOWN,
        EV_DONE,
        EV_TIMEOUT
    } event_t;

    function automatic logic [2:0] mode_code(input state_t s);
        logic [2:0] code;
        unique case (s)
            ST_FREE:  code = MODE_FREE;
            ST_AUTO:  code = MODE_AUTO;
            ST_LEARN: code = MODE_LEARN;
            default:  code = MODE_MENU;
        endcase
        return code;
    endfunction

    // Cursor walks free -> auto -> learn -> free.
    function automatic logic [1:0] cursor_inc(input logic [1:0] c);
        return (c == CUR_LEARN) ? CUR_FREE : c + 2'd1;
    endfunction

    function automatic logic [1:0] song_inc(input logic [1:0] s, input int unsigned cnt);
        return (32'(s) == cnt - 32'd1) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [1:0] song_dec(input logic [1:0] s, input int unsigned cnt);
        return (s == 2'd0) ? 2'(cnt - 32'd1) : s - 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: two-flop synchroniser followed by a stability
// counter. Emits a single-cycle press_pulse when a 0->1 level has been
// stable for DEBOUNCE_CYC cycles; releases and holds produce no pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a new level only after it held for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            level       <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_p0     <= btn_raw;
            sync_p1     <= sync_p0;
            press_pulse <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level       <= sync_p1;
                cnt         <= '0;
                press_pulse <= sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mode_ctrl.sv
// Piano user-mode sequencer. Debounces five buttons, runs the
// MENU/FREE/AUTO/LEARN state machine, tracks the song number and opens a
// mute window on every committed mode or song change.
// Optional feature macro: MODE_TIMEOUT_EN (inactivity return to MENU).
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int unsigned     DEBOUNCE_CYC     = CLK_FREQ_HZ / 50,
    parameter int unsigned     MUTE_CYC         = CLK_FREQ_HZ / 100,
    parameter int unsigned     SONG_CNT         = 4,
    parameter longint unsigned IDLE_TIMEOUT_CYC = 64'd3_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_ok,
    input  logic       btn_back,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       song_done,
    input  logic       key_active,
    output logic [2:0] mode,
    output logic [1:0] song_num,
    output logic [1:0] cursor,
    output logic       mute,
    output logic       switch_pulse
);

    localparam int MUTE_W = $clog2(MUTE_CYC + 1);

    logic [BTN_CNT-1:0] btn_raw;
    logic [BTN_CNT-1:0] press;
    event_t             evt;
    state_t             state;
    state_t             state_nxt;
    logic [1:0]         cursor_nxt;
    logic [1:0]         song_nxt;
    logic               commit;
    logic               timeout_hit;
    logic [MUTE_W-1:0]  mute_cnt;

    assign btn_raw = {btn_down, btn_up, btn_back, btn_ok, btn_next};

    for (genvar i = 0; i < BTN_CNT; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[i]),
            .press_pulse(press[i])
        );
    end

    // Pick the single winning event: back > ok > next > up > down > song_done > timeout.
    always_comb begin
        evt = EV_NONE;
        if (press[BTN_BACK]) begin
            evt = EV_BACK;
        end else if (press[BTN_OK]) begin
            evt = EV_OK;
        end else if (press[BTN_NEXT]) begin
            evt = EV_NEXT;
        end else if (press[BTN_UP]) begin
            evt = EV_UP;
        end else if (press[BTN_DOWN]) begin
            evt = EV_DOWN;
        end else if (song_done) begin
            evt = EV_DONE;
        end else if (timeout_hit) begin
            evt = EV_TIMEOUT;
        end
    end

    // Next state, cursor and song; commit flags any mode or song change.
    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        song_nxt   = song_num;
        commit     = 1'b0;
        unique case (state)
            ST_MENU: begin
                if (evt == EV_NEXT) begin
                    cursor_nxt = cursor_inc(cursor);
                end else if (evt == EV_OK) begin
                    commit = 1'b1;
                    if (cursor == CUR_AUTO) begin
                        state_nxt = ST_AUTO;
                    end else if (cursor == CUR_LEARN) begin
                        state_nxt = ST_LEARN;
                    end else begin
                        state_nxt = ST_FREE;
                    end
                end
            end
            ST_FREE: begin
                if (evt == EV_BACK || evt == EV_TIMEOUT) begin
                    state_nxt = ST_MENU;
                    commit    = 1'b1;
                end
            end
            ST_AUTO: begin
                if (evt == EV_BACK || evt == EV_TIMEOUT) begin
                    state_nxt = ST_MENU;
                    commit    = 1'b1;
                end else if (evt == EV_UP || evt == EV_DONE) begin
                    song_nxt = song_inc(song_num, SONG_CNT);
                    commit   = 1'b1;
                end else if (evt == EV_DOWN) begin
                    song_nxt = song_dec(song_num, SONG_CNT);
                    commit   = 1'b1;
                end
            end
            ST_LEARN: begin
                if (evt == EV_BACK || evt == EV_TIMEOUT || evt == EV_DONE) begin
                    state_nxt = ST_MENU;
                    commit    = 1'b1;
                end else if (evt == EV_UP) begin
                    song_nxt = song_inc(song_num, SONG_CNT);
                    commit   = 1'b1;
                end else if (evt == EV_DOWN) begin
                    song_nxt = song_dec(song_num, SONG_CNT);
                    commit   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_MENU;
            end
        endcase
    end

    // State, cursor, song and the one-cycle commit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_MENU;
            cursor       <= CUR_FREE;
            song_num     <= 2'd0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cursor       <= cursor_nxt;
            song_num     <= song_nxt;
            switch_pulse <= commit;
        end
    end

    // Mute window: every commit (re)loads the full length, then counts down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_cnt <= '0;
        end else if (commit) begin
            mute_cnt <= MUTE_W'(MUTE_CYC);
        end else if (mute_cnt != '0) begin
            mute_cnt <= mute_cnt - MUTE_W'(1);
        end
    end

    assign mode = mode_code(state);
    assign mute = (mute_cnt != '0);

`ifdef MODE_TIMEOUT_EN
    logic [63:0] idle_cnt;
    logic        auto_hold;
    logic        activity;
    logic        idle_frozen;

    // Any accepted press or a held piano key counts as user activity.
    assign activity    = (|press) | key_active;
    // AUTO keeps the counter parked while its song is still playing.
    assign idle_frozen = (state == ST_AUTO) && auto_hold;
    assign timeout_hit = (state != ST_MENU) && !activity && !idle_frozen &&
                         (idle_cnt == IDLE_TIMEOUT_CYC - 64'd1);

    // Inactivity counter and the AUTO song-playing hold flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            auto_hold <= 1'b0;
        end else begin
            if (state_nxt == ST_AUTO && state != ST_AUTO) begin
                auto_hold <= 1'b1;
            end else if (song_done) begin
                auto_hold <= 1'b0;
            end
            if (state == ST_MENU || activity || commit) begin
                idle_cnt <= '0;
            end else if (!idle_frozen) begin
                idle_cnt <= idle_cnt + 64'd1;
            end
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = key_active ^ (IDLE_TIMEOUT_CYC == 64'd0);
`endif

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl with short debounce/mute windows.
// Directed scenarios plus a randomized event sequence checked against a
// transaction-level model of the menu/mode/song rules.
module tb_mode_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned MUTE = 8;
    localparam int unsigned SONGS = 4;
`ifdef MODE_TIMEOUT_EN
    localparam longint unsigned IDLE = 64'd20;
`else
    localparam longint unsigned IDLE = 64'd3_000_000_000;
`endif
    localparam int LAT    = DEB + 3;
    localparam int SETTLE = MUTE;

    localparam int E_NONE = 0;
    localparam int E_BACK = 1;
    localparam int E_OK   = 2;
    localparam int E_NEXT = 3;
    localparam int E_UP   = 4;
    localparam int E_DOWN = 5;
    localparam int E_DONE = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next, btn_ok, btn_back, btn_up, btn_down;
    logic       song_done, key_active;
    logic [2:0] mode;
    logic [1:0] song_num, cursor;
    logic       mute, switch_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [2:0] m_mode;
    int         m_song;
    int         m_cursor;

    mode_ctrl #(
        .DEBOUNCE_CYC    (DEB),
        .MUTE_CYC        (MUTE),
        .SONG_CNT        (SONGS),
        .IDLE_TIMEOUT_CYC(IDLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_next    (btn_next),
        .btn_ok      (btn_ok),
        .btn_back    (btn_back),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .song_done   (song_done),
        .key_active  (key_active),
        .mode        (mode),
        .song_num    (song_num),
        .cursor      (cursor),
        .mute        (mute),
        .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model and stimulus helpers ----------------
    task automatic model_step(input int ev, output bit sw);
        sw = 1'b0;
        if (m_mode == 3'b000) begin
            if (ev == E_NEXT) m_cursor = (m_cursor + 1) % 3;
            else if (ev == E_OK) begin
                m_mode = (m_cursor == 0) ? 3'b001 : (m_cursor == 1) ? 3'b011 : 3'b111;
                sw = 1'b1;
            end
        end else if (ev == E_BACK) begin
            m_mode = 3'b000;
            sw = 1'b1;
        end else if (m_mode != 3'b001) begin
            if (ev == E_UP) begin
                m_song = (m_song + 1) % SONGS;
                sw = 1'b1;
            end else if (ev == E_DOWN) begin
                m_song = (m_song + SONGS - 1) % SONGS;
                sw = 1'b1;
            end else if (ev == E_DONE) begin
                if (m_mode == 3'b011) m_song = (m_song + 1) % SONGS;
                else m_mode = 3'b000;
                sw = 1'b1;
            end
        end
    endtask

    function automatic int pick_event(input logic [4:0] m);
        if (m[2]) return E_BACK;
        if (m[1]) return E_OK;
        if (m[0]) return E_NEXT;
        if (m[3]) return E_UP;
        if (m[4]) return E_DOWN;
        return E_NONE;
    endfunction

    function automatic logic [4:0] ev_mask(input int ev);
        case (ev)
            E_NEXT: return 5'b00001;
            E_OK:   return 5'b00010;
            E_BACK: return 5'b00100;
            E_UP:   return 5'b01000;
            E_DOWN: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_down, btn_up, btn_back, btn_ok, btn_next} = m;
    endtask

    // Hold buttons until the committed update is visible.
    task automatic press_hold(input logic [4:0] m, output bit sw);
        set_btns(m);
        tick(LAT);
        model_step(pick_event(m), sw);
    endtask

    task automatic release_all;
        set_btns(5'b0);
        tick(SETTLE);
    endtask

    task automatic press(input logic [4:0] m);
        bit sw;
        press_hold(m, sw);
        release_all();
    endtask

    task automatic pulse_done(output bit sw);
        song_done = 1'b1;
        tick(1);
        song_done = 1'b0;
        model_step(E_DONE, sw);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        set_btns(5'b0);
        song_done  = 1'b0;
        key_active = 1'b1;
        m_mode = 3'b000; m_song = 0; m_cursor = 0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        n_checks++; if (mode !== 3'b000) begin n_fail++; $display("FAIL reset_mode: got %b want 000", mode); end
        n_checks++; if (song_num !== 2'd0) begin n_fail++; $display("FAIL reset_song: got %0d want 0", song_num); end
        n_checks++; if (cursor !== 2'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
        n_checks++; if (mute !== 1'b0) begin n_fail++; $display("FAIL reset_mute: got %b want 0", mute); end
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", switch_pulse); end
    endtask

`ifdef MODE_TIMEOUT_EN
    task automatic test_timeout;
        bit sw;
        key_active = 1'b0;
        press_hold(5'b00010, sw);
        set_btns(5'b0);
        tick(19);
        n_checks++; if (mode !== 3'b001) begin n_fail++; $display("FAIL tmo_early: got %b want 001", mode); end
        tick(1);
        n_checks++; if (mode !== 3'b000 || switch_pulse !== 1'b1) begin
            n_fail++; $display("FAIL tmo_fire: mode %b pulse %b want 000/1", mode, switch_pulse); end
        m_mode = 3'b000;
        tick(SETTLE);
        press_hold(5'b00010, sw);
        set_btns(5'b0);
        tick(14);
        key_active = 1'b1;
        tick(1);
        key_active = 1'b0;
        tick(19);
        n_checks++; if (mode !== 3'b001) begin n_fail++; $display("FAIL tmo_key_hold: got %b want 001", mode); end
        tick(1);
        n_checks++; if (mode !== 3'b000) begin n_fail++; $display("FAIL tmo_key_fire: got %b want 000", mode); end
        m_mode = 3'b000;
        key_active = 1'b1;
        tick(SETTLE);
    endtask
`endif

    task automatic test_ok_latency;
        bit sw;
        int mute_hi, pulses;
        set_btns(5'b00010);
        tick(LAT - 1);
        n_checks++; if (mode !== 3'b000) begin n_fail++; $display("FAIL ok_early: got %b want 000", mode); end
        tick(1);
        model_step(E_OK, sw);
        n_checks++; if (mode !== 3'b001) begin n_fail++; $display("FAIL ok_mode: got %b want 001", mode); end
        mute_hi = 0; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (mute === 1'b1) mute_hi++;
            if (switch_pulse === 1'b1) pulses++;
            tick(1);
        end
        n_checks++; if (mute_hi != 8) begin n_fail++; $display("FAIL ok_mute_len: got %0d want 8", mute_hi); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ok_pulse_cnt: got %0d want 1", pulses); end
        release_all();
        press(5'b00100);
        n_checks++; if (mode !== 3'b000) begin n_fail++; $display("FAIL back_menu: got %b want 000", mode); end
    endtask

    task automatic test_menu_nav;
        bit sw;
        int exp_cur [3] = '{1, 2, 0};
        for (int i = 0; i < 3; i++) begin
            press_hold(5'b00001, sw);
            n_checks++; if (cursor !== 2'(exp_cur[i]) || switch_pulse !== 1'b0) begin
                n_fail++; $display("FAIL next_cursor%0d: got %0d/%b want %0d/0", i, cursor, switch_pulse, exp_cur[i]); end
            release_all();
        end
        btn_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            tick(2);
        end
        tick(SETTLE);
        n_checks++; if (cursor !== 2'd0) begin n_fail++; $display("FAIL bounce_cursor: got %0d want 0", cursor); end
        press(5'b00001);
        press_hold(5'b00010, sw);
        n_checks++; if (mode !== 3'b011 || switch_pulse !== 1'b1) begin
            n_fail++; $display("FAIL enter_auto: mode %b pulse %b want 011/1", mode, switch_pulse); end
        release_all();
    endtask

    task automatic test_auto_songs;
        bit sw;
        int mute_hi;
        press_hold(5'b10000, sw);
        n_checks++; if (song_num !== 2'd3) begin n_fail++; $display("FAIL down_wrap: got %0d want 3", song_num); end
        release_all();
        press(5'b01000);
        press_hold(5'b01000, sw);
        n_checks++; if (song_num !== 2'd1) begin n_fail++; $display("FAIL up_up: got %0d want 1", song_num); end
        release_all();
        pulse_done(sw);
        n_checks++; if (song_num !== 2'd2 || mode !== 3'b011 || switch_pulse !== 1'b1) begin
            n_fail++; $display("FAIL auto_done: song %0d mode %b pulse %b want 2/011/1", song_num, mode, switch_pulse); end
        tick(4);
        pulse_done(sw);
        mute_hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (mute === 1'b1) mute_hi++;
            tick(1);
        end
        n_checks++; if (mute_hi != 8) begin n_fail++; $display("FAIL mute_reload: got %0d want 8", mute_hi); end
    endtask

    task automatic test_learn;
        bit sw;
        press(5'b00100);
        press(5'b00001);
        press_hold(5'b00010, sw);
        n_checks++; if (mode !== 3'b111) begin n_fail++; $display("FAIL enter_learn: got %b want 111", mode); end
        release_all();
        press(5'b10000);
        pulse_done(sw);
        n_checks++; if (mode !== 3'b000 || song_num !== 2'd2 || switch_pulse !== 1'b1) begin
            n_fail++; $display("FAIL learn_done: mode %b song %0d pulse %b want 000/2/1", mode, song_num, switch_pulse); end
        tick(SETTLE);
        press(5'b00010);
        press_hold(5'b01100, sw);
        n_checks++; if (mode !== 3'b000 || song_num !== 2'd2) begin
            n_fail++; $display("FAIL back_vs_up: mode %b song %0d want 000/2", mode, song_num); end
        release_all();
    endtask

    task automatic test_done_vs_button;
        bit sw;
        press(5'b00001);
        press(5'b00001);
        press(5'b00010);
        set_btns(5'b10000);
        tick(LAT - 1);
        song_done = 1'b1;
        tick(1);
        song_done = 1'b0;
        model_step(E_DOWN, sw);
        n_checks++; if (mode !== 3'b011 || song_num !== 2'd1) begin
            n_fail++; $display("FAIL done_vs_down: mode %b song %0d want 011/1", mode, song_num); end
        release_all();
    endtask

    task automatic test_random;
        bit sw;
        int ev;
        for (int i = 0; i < 40; i++) begin
            ev = int'($urandom_range(1, 6));
            if (ev == E_DONE) pulse_done(sw);
            else press_hold(ev_mask(ev), sw);
            n_checks++;
            if (mode !== m_mode || song_num !== 2'(m_song) || cursor !== 2'(m_cursor) || switch_pulse !== sw) begin
                n_fail++;
                $display("FAIL rand%0d ev%0d: got mode %b song %0d cur %0d pulse %b want %b %0d %0d %b",
                         i, ev, mode, song_num, cursor, switch_pulse, m_mode, m_song, m_cursor, sw);
            end
            if (ev == E_DONE) tick(SETTLE);
            else release_all();
            n_checks++; if (mute !== 1'b0) begin n_fail++; $display("FAIL rand%0d_mute_end: got %b want 0", i, mute); end
        end
    endtask

    task automatic test_async_reset;
        bit sw;
        if (m_mode != 3'b000) press(5'b00100);
        while (m_cursor != 1) press(5'b00001);
        press(5'b00010);
        if (m_song == 3) press(5'b01000);
        press_hold(5'b01000, sw);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mode !== 3'b000 || song_num !== 2'd0 || mute !== 1'b0 || switch_pulse !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: mode %b song %0d mute %b pulse %b want 000/0/0/0",
                               mode, song_num, mute, switch_pulse); end
        set_btns(5'b0);
        tick(2);
        rst_n = 1'b1;
        m_mode = 3'b000; m_song = 0; m_cursor = 0;
        tick(1);
        n_checks++; if (cursor !== 2'd0 || mode !== 3'b000) begin
            n_fail++; $display("FAIL after_reset: cursor %0d mode %b want 0/000", cursor, mode); end
    endtask

    initial begin
        test_reset();
`ifdef MODE_TIMEOUT_EN
        test_timeout();
`endif
        test_ok_latency();
        test_menu_nav();
        test_auto_songs();
        test_learn();
        test_done_vs_button();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
